// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and line-level bit constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/tx_serializer.sv
// Load/shift register and data-bit counter for the UART transmitter, LSB first.
module tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ser_bit,
  output logic                  ser_done
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;
  logic                  first;

  assign ser_bit  = shreg[0];
  assign ser_done = !first && (cnt == LAST);

  // The first shift (leaving START) puts bit 0 on the line; cnt stays at 0 so it
  // indexes the bit currently being presented throughout DATA.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shreg <= '0;
      cnt   <= '0;
      first <= 1'b0;
    end else if (load) begin
      shreg <= data;
      cnt   <= '0;
      first <= 1'b1;
    end else if (shift_en) begin
      shreg <= shreg >> 1;
      if (first)
        first <= 1'b0;
      else if (!ser_done)
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one frame bit per CLK; start, DATA_WIDTH data bits LSB first, optional parity, stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  state_t state;
  logic   par_en_q;
  logic   par_bit_q;
  logic   load;
  logic   shift_en;
  logic   ser_bit;
  logic   ser_done;

  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d, input logic typ);
    return (typ == PAR_ODD) ? ~^d : ^d;
  endfunction

  assign load     = (state == IDLE) && DATA_VALID;
  assign shift_en = (state == START) || ((state == DATA) && !ser_done);

  tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .CLK      (CLK),
    .RST      (RST),
    .load     (load),
    .shift_en (shift_en),
    .data     (P_DATA),
    .ser_bit  (ser_bit),
    .ser_done (ser_done)
  );

  // Parity is resolved from the word as it is latched, so later input changes cannot affect it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      TX_OUT    <= STOP_BIT;
      Busy      <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (DATA_VALID) begin
            par_en_q  <= PAR_EN;
            par_bit_q <= parity_of(P_DATA, PAR_TYP);
            state     <= START;
            TX_OUT    <= START_BIT;
            Busy      <= 1'b1;
          end else begin
            TX_OUT <= STOP_BIT;
            Busy   <= 1'b0;
          end
        end
        START: begin
          state  <= DATA;
          TX_OUT <= ser_bit;
        end
        DATA: begin
          if (ser_done) begin
            if (par_en_q) begin
              state  <= PARITY;
              TX_OUT <= par_bit_q;
            end else begin
              state  <= STOP;
              TX_OUT <= STOP_BIT;
            end
          end else begin
            TX_OUT <= ser_bit;
          end
        end
        PARITY: begin
          state  <= STOP;
          TX_OUT <= STOP_BIT;
        end
        STOP: begin
          state  <= IDLE;
          TX_OUT <= STOP_BIT;
          Busy   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= STOP_BIT;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-queue reference model checked every cycle, plus literal frame expectations.
module tb_uart_tx;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic chk_on   = 1'b0;
  logic lit_en   = 1'b0;
  logic lit_tx   = 1'b1;
  logic lit_busy = 1'b0;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model: a frame is a list of line bits; the line shows one per cycle.
  logic q_bits[$];
  logic m_tx   = 1'b1;
  logic m_busy = 1'b0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q_bits.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end else begin
      if (!m_busy && DATA_VALID) begin
        int pc;
        pc = $countones(P_DATA);
        q_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) q_bits.push_back(P_DATA[i]);
        if (PAR_EN) q_bits.push_back(PAR_TYP ? (pc % 2 == 0) : (pc % 2 == 1));
        q_bits.push_back(1'b1);
      end
      if (q_bits.size() > 0) begin
        m_tx   = q_bits.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      n_chk++;
      if (TX_OUT !== m_tx) begin
        n_fail++;
        $display("FAIL model_tx_out t=%0t got %b want %b", $time, TX_OUT, m_tx);
      end
      n_chk++;
      if (Busy !== m_busy) begin
        n_fail++;
        $display("FAIL model_busy t=%0t got %b want %b", $time, Busy, m_busy);
      end
      if (lit_en) begin
        n_chk++;
        if (TX_OUT !== lit_tx) begin
          n_fail++;
          $display("FAIL literal_tx_out t=%0t got %b want %b", $time, TX_OUT, lit_tx);
        end
        n_chk++;
        if (Busy !== lit_busy) begin
          n_fail++;
          $display("FAIL literal_busy t=%0t got %b want %b", $time, Busy, lit_busy);
        end
      end
    end
  end

  task automatic lit(input logic t, input logic b);
    lit_tx   = t;
    lit_busy = b;
    lit_en   = 1'b1;
    @(negedge CLK);
    #1 lit_en = 1'b0;
  endtask

  task automatic check_bits(input logic [10:0] exp, input int from, input int len);
    for (int k = from; k < len; k++) lit(exp[k], 1'b1);
  endtask

  // Pulses DATA_VALID for one cycle, then scrambles the inputs to show they were latched.
  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt);
    @(posedge CLK);
    #1;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    DATA_VALID = 1'b1;
    @(posedge CLK);
    #1;
    DATA_VALID = 1'b0;
    P_DATA     = 8'($urandom);
    PAR_EN     = 1'($urandom);
    PAR_TYP    = 1'($urandom);
  endtask

  initial begin
    RST        = 1'b1;
    P_DATA     = '0;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    #2 RST = 1'b0;
    #1 chk_on = 1'b1;
    lit(1'b1, 1'b0);
    lit(1'b1, 1'b0);
    RST = 1'b1;
    lit(1'b1, 1'b0);

    // A5 without parity, then with even and odd parity
    start_frame(8'hA5, 1'b0, 1'b0);
    check_bits(11'b00_1101001010, 0, 10);
    lit(1'b1, 1'b0);
    start_frame(8'hA5, 1'b1, 1'b0);
    check_bits(11'b10101001010, 0, 11);
    lit(1'b1, 1'b0);
    start_frame(8'hA5, 1'b1, 1'b1);
    check_bits(11'b11101001010, 0, 11);
    lit(1'b1, 1'b0);

    // 01 with even then odd parity
    start_frame(8'h01, 1'b1, 1'b0);
    check_bits(11'b11000000010, 0, 11);
    lit(1'b1, 1'b0);
    start_frame(8'h01, 1'b1, 1'b1);
    check_bits(11'b10000000010, 0, 11);
    lit(1'b1, 1'b0);

    // DATA_VALID held: 3C frame, one idle cycle, then C3 frame
    @(posedge CLK);
    #1;
    P_DATA     = 8'h3C;
    PAR_EN     = 1'b0;
    DATA_VALID = 1'b1;
    @(posedge CLK);
    #1 P_DATA = 8'hC3;
    check_bits(11'b00_1001111000, 0, 10);
    lit(1'b1, 1'b0);
    lit(1'b0, 1'b1);
    DATA_VALID = 1'b0;
    check_bits(11'b00_1110000110, 1, 10);
    lit(1'b1, 1'b0);

    // DATA_VALID pulse with FF during DATA is ignored
    start_frame(8'h5A, 1'b1, 1'b1);
    check_bits(11'b11010110100, 0, 3);
    P_DATA     = 8'hFF;
    DATA_VALID = 1'b1;
    lit(1'b0, 1'b1);
    DATA_VALID = 1'b0;
    check_bits(11'b11010110100, 4, 11);
    lit(1'b1, 1'b0);
    lit(1'b1, 1'b0);
    lit(1'b1, 1'b0);

    // Reset during data bit 3, then a clean 55 frame
    start_frame(8'hA5, 1'b0, 1'b0);
    check_bits(11'b00_1101001010, 0, 4);
    @(posedge CLK);
    #2 RST = 1'b0;
    lit(1'b1, 1'b0);
    lit(1'b1, 1'b0);
    RST = 1'b1;
    lit(1'b1, 1'b0);
    start_frame(8'h55, 1'b0, 1'b0);
    check_bits(11'b00_1010101010, 0, 10);
    lit(1'b1, 1'b0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      @(posedge CLK);
      #1;
      DATA_VALID = ($urandom_range(0, 3) != 0);
      P_DATA     = 8'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
    end
    DATA_VALID = 1'b0;
    repeat (15) @(posedge CLK);
    @(negedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
